// File: rtl/bus_responder.sv
// bus_responder: CPU-side address/data responder backed by a tagged word store.
// Ports:
//   clk      - single clock, all state on rising edge
//   reset    - asynchronous active-low reset
//   i_ad     - address on strobe cycle, write data on write cycle
//   i_tag    - write tag, sampled on write cycle
//   i_astb   - address strobe
//   i_atomic - read-modify-write flag, sampled with i_astb
//   i_rd     - read request
//   i_wr     - write request
//   o_data   - read data, held until the next completed read
//   o_tag    - read tag, held with o_data
//   o_valid  - one-cycle pulse when o_data/o_tag update
//   o_err    - one-cycle pulse on protocol violation or out-of-range access
module bus_responder #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_ad,
  input  logic [7:0]  i_tag,
  input  logic        i_astb,
  input  logic        i_atomic,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [63:0] o_data,
  output logic [7:0]  o_tag,
  output logic        o_valid,
  output logic        o_err
);
  typedef enum logic [1:0] {IDLE, ADDR, LOCK_RD, LOCK_WR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic oor;
  logic [71:0] mem [2**ADDR_W];
  logic strobe, do_rd, do_wr, viol, err_q;
  logic [RD_LAT-1:0] pv, pe, nv, ne;
  logic [71:0] pd [RD_LAT];
  logic [71:0] nd [RD_LAT];
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = strobe ? (i_atomic ? LOCK_RD : ADDR) :
               (do_rd && state == LOCK_RD) ? LOCK_WR :
               (do_wr && state == LOCK_WR) ? IDLE : state;
  // Any access sharing a cycle with a strobe or with the opposite access is dropped.
  always_comb begin
    strobe = i_astb && (state == IDLE || state == ADDR);
    do_rd  = i_rd && !i_wr && !i_astb && (state == ADDR || state == LOCK_RD);
    do_wr  = i_wr && !i_rd && !i_astb && (state == ADDR || state == LOCK_WR);
    viol   = (i_rd && i_wr) || (i_astb && (i_rd || i_wr)) ||
             (i_astb && (state == LOCK_RD || state == LOCK_WR)) ||
             (i_rd && !(state == ADDR || state == LOCK_RD)) ||
             (i_wr && !(state == ADDR || state == LOCK_WR));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr <= '0;
      oor  <= 1'b0;
    end else if (strobe) begin
      addr <= i_ad[ADDR_W-1:0];
      oor  <= |i_ad[19:ADDR_W];
    end
  always_ff @(posedge clk)
    if (do_wr && !oor) mem[addr] <= {i_tag, i_ad};
  // Stage 0 captures the store word at issue, so a write issued later never
  // leaks into an earlier read. The last stage doubles as the held output.
  always_comb begin
    nv[0] = do_rd;
    ne[0] = oor;
    nd[0] = oor ? '0 : mem[addr];
    for (int k = 1; k < RD_LAT; k++) begin
      nv[k] = pv[k-1];
      ne[k] = pe[k-1];
      nd[k] = pd[k-1];
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pv    <= '0;
      pe    <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) pd[k] <= '0;
    end else begin
      pv    <= nv;
      pe    <= ne;
      err_q <= viol || (do_wr && oor);
      for (int k = 0; k < RD_LAT; k++)
        if (k < RD_LAT - 1 || nv[k]) pd[k] <= nd[k];
    end
  assign o_data  = pd[RD_LAT-1][63:0];
  assign o_tag   = pd[RD_LAT-1][71:64];
  assign o_valid = pv[RD_LAT-1];
  assign o_err   = err_q || (pv[RD_LAT-1] && pe[RD_LAT-1]);
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: randomized check of bus_responder against a transaction-level model.
module tb_bus_responder;
  localparam int RD_LAT = 3;
  logic clk = 1'b0, reset = 1'b0;
  logic [63:0] i_ad = '0;
  logic [7:0] i_tag = '0;
  logic i_astb = 1'b0, i_atomic = 1'b0, i_rd = 1'b0, i_wr = 1'b0;
  logic [63:0] o_data;
  logic [7:0] o_tag;
  logic o_valid, o_err;
  int checks = 0, errors = 0;
  bus_responder #(.ADDR_W(12), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
    .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .o_data(o_data),
    .o_tag(o_tag), .o_valid(o_valid), .o_err(o_err));
  always #5 clk = ~clk;
  typedef struct {int due; logic [71:0] d; bit e;} comp_t;
  comp_t q[$];
  logic [71:0] mm [int];
  logic [71:0] held = '0;
  logic [11:0] am = '0;
  bit have = 0, oorm = 0;
  int lk = 0;
  int cyc = 0;
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic a, at, r, w, input logic [63:0] ad, input logic [7:0] tg);
    bit bad, rd_ok, wr_ok, werr, ev, ee;
    comp_t c;
    i_astb = a; i_atomic = at; i_rd = r; i_wr = w; i_ad = ad; i_tag = tg;
    @(posedge clk);
    cyc++;
    bad = (r && w) || (a && (r || w)) || (a && lk != 0) ||
          (r && (!have || lk == 2)) || (w && (!have || lk == 1));
    rd_ok = r && !w && !a && have && lk != 2;
    wr_ok = w && !r && !a && have && lk != 1;
    werr = 0;
    if (rd_ok) begin
      c.due = cyc + RD_LAT - 1;
      c.d = oorm ? 72'h0 : mm[int'(am)];
      c.e = oorm;
      q.push_back(c);
      if (lk == 1) lk = 2;
    end
    if (wr_ok) begin
      if (oorm) werr = 1;
      else mm[int'(am)] = {tg, ad};
      if (lk == 2) begin lk = 0; have = 0; end
    end
    if (a && lk == 0) begin
      am = ad[11:0];
      oorm = |ad[19:12];
      have = 1;
      lk = at ? 1 : 0;
    end
    ev = q.size() > 0 && q[0].due == cyc;
    ee = bad || werr || (ev && q[0].e);
    if (ev) begin
      held = q[0].d;
      void'(q.pop_front());
    end
    #1;
    chk("valid", o_valid, ev);
    chk("err", o_err, ee);
    chk("data", o_data, held[63:0]);
    chk("tag", o_tag, held[71:64]);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 64'h0, 8'h0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    i_astb = 0; i_atomic = 0; i_rd = 0; i_wr = 0;
    reset = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_data", o_data, 0);
    chk("rst_tag", o_tag, 0);
    q.delete();
    have = 0; lk = 0; am = '0; oorm = 0; held = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    logic a, at, r, w;
    logic [63:0] ad;
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_data", o_data, 0);
    chk("rst_tag", o_tag, 0);
    #10 reset = 1'b1;
    step(0, 0, 1, 0, 64'h0, 8'h0);
    step(0, 0, 1, 1, 64'h0, 8'h0);
    for (int k = 0; k < 64; k++) begin
      step(1, 0, 0, 0, 64'(k), 8'h0);
      step(0, 0, 0, 1, {$urandom, $urandom}, 8'($urandom));
    end
    step(1, 0, 0, 0, 64'h10, 8'h0);
    step(0, 0, 0, 1, 64'h0123456789ABCDEF, 8'h35);
    step(0, 0, 1, 0, 64'h0, 8'h0);
    idle(RD_LAT);
    chk("r030_data", o_data, 64'h0123456789ABCDEF);
    chk("r030_tag", o_tag, 8'h35);
    step(1, 1, 0, 0, 64'h20, 8'h0);
    step(0, 0, 1, 0, 64'h0, 8'h0);
    step(0, 0, 0, 1, 64'h5, 8'h1);
    step(1, 0, 0, 0, 64'h20, 8'h0);
    step(0, 0, 1, 0, 64'h0, 8'h0);
    idle(RD_LAT);
    chk("r031_data", o_data, 64'h5);
    chk("r031_tag", o_tag, 8'h1);
    step(1, 1, 0, 0, 64'h7, 8'h0);
    step(1, 1, 0, 0, 64'h9, 8'h0);
    step(0, 0, 1, 0, 64'h0, 8'h0);
    step(0, 0, 0, 1, 64'hFACE, 8'h77);
    idle(RD_LAT);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 0, 0, 64'(k), 8'h0);
      step(0, 0, 1, 0, 64'h0, 8'h0);
    end
    step(0, 0, 1, 0, 64'h0, 8'h0);
    step(0, 0, 1, 0, 64'h0, 8'h0);
    idle(RD_LAT + 1);
    step(1, 0, 0, 0, 64'h2, 8'h0);
    step(0, 0, 1, 0, 64'h0, 8'h0);
    step(0, 0, 1, 0, 64'h0, 8'h0);
    do_reset();
    idle(RD_LAT + 2);
    step(1, 0, 0, 0, 64'h1_0000, 8'h0);
    step(0, 0, 0, 1, 64'hDEAD, 8'hAA);
    step(0, 0, 1, 0, 64'h0, 8'h0);
    idle(RD_LAT);
    step(1, 0, 0, 0, 64'h0, 8'h0);
    step(0, 0, 1, 0, 64'h0, 8'h0);
    idle(RD_LAT);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      a = $urandom_range(0, 99) < 20;
      at = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99) < 40;
      w = $urandom_range(0, 99) < 25;
      ad = a ? ($urandom_range(0, 9) == 0 ? 64'h1000 | 64'($urandom_range(0, 63))
                                          : 64'($urandom_range(0, 63)))
             : {$urandom, $urandom};
      step(a, at, r, w, ad, 8'($urandom));
    end
    idle(RD_LAT + 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
